// File: rtl/axi_read_burst_ctrl.sv
// AXI4 read-address/read-data sequencer for the VDMA read path: normal bursts, then one tail burst.
// Optional: define READ_RESP_CHECK_EN to also flag SLVERR/DECERR responses in rd_err.
module axi_read_burst_ctrl #(
  parameter int unsigned NOR_BURST_LEN = 200,
  parameter int unsigned AXI_DSIZE     = 256,
  parameter int unsigned ASIZE         = 32,
  parameter int unsigned LSIZE         = 9,
  parameter int unsigned IDSIZE        = 4,
  parameter int unsigned DONE_HOLD     = 4,
  parameter int unsigned SETTLE        = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              fsync,
  input  logic [ASIZE-1:0]  base_addr,
  input  logic              fifo_afull,
  input  logic              tail_status,
  input  logic [LSIZE-1:0]  tail_len,
  output logic              burst_done,
  output logic              tail_done,
  output logic              busy,
  output logic              rd_err,
  output logic [IDSIZE-1:0] arid,
  output logic [ASIZE-1:0]  araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rvalid,
  input  logic              rlast,
  input  logic [1:0]        rresp,
  output logic              rready
);

  // Burst length must hold 256 as well as any tail_len value.
  localparam int unsigned BlenW     = (LSIZE > 9) ? LSIZE : 9;
  localparam int unsigned BeatShift = $clog2(AXI_DSIZE / 8);
  localparam int unsigned CntW      = 8;
  localparam logic [BlenW-1:0] NorLen = BlenW'(NOR_BURST_LEN);

  typedef enum logic [2:0] {
    StIdle, StWaitLen, StCheck, StAddr, StData, StDone, StSettle
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ASIZE-1:0]   cur_addr_q, pend_addr_q;
  logic               pend_q, is_tail_q, busy_q, rd_err_q;
  logic [BlenW-1:0]   blen_q, beat_cnt_q, blen_sel;
  logic [7:0]         arlen_q;
  logic               in_bus, reload, beat_acc, last_acc, drain_restart;
  logic               latch_len, len_err, resp_err;

  assign in_bus        = (state_q == StAddr) || (state_q == StData);
  assign reload        = fsync && !in_bus;
  assign beat_acc      = rvalid && rready;
  assign last_acc      = beat_acc && rlast;
  assign drain_restart = last_acc && (pend_q || fsync);
  assign latch_len     = (state_q == StCheck) && !fsync && !fifo_afull;
  assign blen_sel      = (tail_status && (tail_len != '0)) ? BlenW'(tail_len) : NorLen;
  assign len_err       = last_acc && ((beat_cnt_q + BlenW'(1)) != blen_q);

`ifdef READ_RESP_CHECK_EN
  assign resp_err = beat_acc && rresp[1];
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign resp_err     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (fsync) state_d = StWaitLen;
      StWaitLen: if (!fsync && (cnt_q == CntW'(1))) state_d = StCheck;
      StCheck: begin
        if (fsync)            state_d = StWaitLen;
        else if (!fifo_afull) state_d = StAddr;
      end
      StAddr:    if (arready) state_d = StData;
      StData:    if (last_acc) state_d = drain_restart ? StWaitLen : StDone;
      StDone: begin
        if (fsync)                                 state_d = StWaitLen;
        else if (cnt_q == CntW'(DONE_HOLD - 1))    state_d = is_tail_q ? StIdle : StSettle;
      end
      StSettle: begin
        if (fsync)                                 state_d = StWaitLen;
        else if (cnt_q == CntW'(SETTLE - 1))       state_d = StCheck;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    burst_done = 1'b0;
    tail_done  = 1'b0;
    unique case (state_q)
      StAddr:  arvalid = 1'b1;
      StData:  rready  = 1'b1;
      StDone: begin
        tail_done  = is_tail_q;
        burst_done = !is_tail_q;
      end
      default: ;
    endcase
  end

  // Dwell counter restarts on every state change and on an fsync reload.
  assign cnt_d = ((state_d != state_q) || reload) ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cur_addr_q  <= '0;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      is_tail_q   <= 1'b0;
      blen_q      <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;

      if (reload) begin
        cur_addr_q <= base_addr;
      end else if (drain_restart) begin
        cur_addr_q <= fsync ? base_addr : pend_addr_q;
      end else if (last_acc) begin
        cur_addr_q <= cur_addr_q + (ASIZE'(blen_q) << BeatShift);
      end

      // A frame start during a bus transaction is deferred until the burst drains.
      if (fsync && in_bus) pend_addr_q <= base_addr;
      if (drain_restart)        pend_q <= 1'b0;
      else if (fsync && in_bus) pend_q <= 1'b1;

      if (latch_len) begin
        is_tail_q <= tail_status;
        blen_q    <= blen_sel;
        arlen_q   <= 8'(blen_sel - BlenW'(1));
      end

      if (state_q == StAddr) beat_cnt_q <= '0;
      else if (beat_acc)     beat_cnt_q <= beat_cnt_q + BlenW'(1);

      if (fsync)                                          busy_q <= 1'b1;
      else if ((state_q == StDone) && (state_d == StIdle)) busy_q <= 1'b0;

      if (len_err || resp_err) rd_err_q <= 1'b1;
      else if (fsync)          rd_err_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign rd_err  = rd_err_q;
  assign arid    = '0;
  assign araddr  = cur_addr_q;
  assign arlen   = arlen_q;
  assign arsize  = 3'(BeatShift);
  assign arburst = 2'b01;

endmodule

// File: doc/axi_read_burst_ctrl.md
Name: axi_read_burst_ctrl

Overview:
- AXI4 read-address/read-data sequencer for the VDMA read path; consumes tail_status/tail_len from the line/frame length tracker and returns burst_done/tail_done to it.
- Per frame (fsync) issues NOR_BURST_LEN-beat INCR bursts from base_addr, then one tail burst of tail_len beats.
- rdata goes straight to the read FIFO; this block only drives the AR channel, rready and the completion handshakes.

Parameters:
- NOR_BURST_LEN, 200, normal burst length in beats (1..256).
- AXI_DSIZE, 256, AXI data width in bits (power of 2, 8..1024).
- ASIZE, 32, address width.
- LSIZE, 9, width of tail_len.
- IDSIZE, 4, AXI ID width.
- DONE_HOLD, 4, cycles burst_done/tail_done are held high (min 2).
- SETTLE, 4, cycles waited after a done before sampling tail_status again (min 3).

Ports:
- clock, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- fsync, in, 1, frame start pulse.
- base_addr, in, ASIZE, frame base byte address (sampled on fsync).
- fifo_afull, in, 1, downstream FIFO cannot accept a full burst.
- tail_status, in, 1, remaining beats < NOR_BURST_LEN.
- tail_len, in, LSIZE, tail burst length in beats.
- burst_done, out, 1, normal burst complete (level, DONE_HOLD cycles).
- tail_done, out, 1, tail burst complete (level, DONE_HOLD cycles).
- busy, out, 1, frame in progress.
- rd_err, out, 1, sticky error flag, cleared on fsync.
- arid, out, IDSIZE, constant 0.
- araddr, out, ASIZE, burst address.
- arlen, out, 8, beats-1.
- arsize, out, 3, log2(AXI_DSIZE/8).
- arburst, out, 2, constant 2'b01 (INCR).
- arvalid, in/out: out, 1, address valid.
- arready, in, 1, address accepted.
- rvalid, in, 1, read beat valid.
- rlast, in, 1, last beat.
- rresp, in, 2, read response.
- rready, out, 1, read beat accept.

Behaviour:
- Reset (synchronous, rst_n=0): state IDLE; arvalid, rready, burst_done, tail_done, busy, rd_err = 0; araddr = 0; arlen = 0. Reset mid-burst aborts immediately; the bus is then owned by the interconnect reset.
- States:
  - IDLE: wait for fsync.
  - WAIT_LEN: 2 cycles, letting the length tracker reload.
  - CHECK: if fifo_afull, stay. Else latch blen = tail_status ? tail_len : NOR_BURST_LEN and is_tail = tail_status, then go to ADDR.
  - ADDR: arvalid=1, araddr=cur_addr, arlen=blen-1. On arvalid&arready go to DATA the next cycle.
  - DATA: rready=1. Count beats on rvalid&rready. The beat where rlast=1 ends the burst, then go to DONE.
  - DONE: assert is_tail ? tail_done : burst_done for DONE_HOLD cycles. cur_addr += blen*(AXI_DSIZE/8). Then go to IDLE if is_tail, else SETTLE.
  - SETTLE: wait SETTLE cycles, then go to CHECK.
- fsync handling:
  - fsync in any state: busy=1 and rd_err cleared.
  - In IDLE/WAIT_LEN/CHECK/SETTLE/DONE: reload cur_addr=base_addr, go to WAIT_LEN, and drop any done output immediately.
  - In ADDR or DATA: set restart_pend. AXI rules hold, so arvalid stays high until arready and all beats are drained. After rlast, skip DONE (no done pulse), reload base_addr and go to WAIT_LEN.
- busy clears on leaving DONE for IDLE.
- rlast on beat count != blen: rd_err=1; the burst still ends at rlast.
- Beats after rlast are impossible in DATA because rready drops.
- arlen = (blen-1)[7:0]. blen == 0 from tail_len is treated as NOR_BURST_LEN.
- Address arithmetic wraps modulo 2^ASIZE. No 4 KB splitting: software aligns base_addr and sizes.
- Latency: fsync to arvalid = 3 cycles (fifo_afull=0). rlast to done high = 1 cycle.

Optional Feature:
- Macro READ_RESP_CHECK_EN.
- Defined: any accepted beat with rresp[1]=1 (SLVERR/DECERR) sets rd_err.
- Undefined: rresp is ignored and rd_err reflects only rlast/length mismatch.

Test Plan:
- Setup for the first four scenarios: NOR_BURST_LEN=16, AXI_DSIZE=256, line of 180 beats (tracker model), base 0x1000_0000.
  - Full line: fsync, always-ready slave -> 11 bursts arlen=15 at 0x1000_0000 + n*0x200, then arlen=3 at 0x1000_1600. 11 burst_done, 1 tail_done each 4 cycles wide; busy low after tail.
  - Backpressure: fifo_afull=1 for 50 cycles during SETTLE -> no arvalid until release; addresses unchanged.
  - arready stalled 10 cycles -> arvalid and araddr stable throughout; single handshake.
  - fsync mid-DATA (beat 5 of 16) -> remaining 11 beats accepted, no burst_done, next araddr = new base_addr 3 cycles after rlast-path completion.
- Short rlast: slave asserts rlast on beat 12 of 16 -> rd_err=1, burst_done still pulses; next fsync clears rd_err.
- With READ_RESP_CHECK_EN: rresp=2'b10 on one beat -> rd_err=1. Without the macro -> rd_err stays 0.
